// File: rtl/uart_pkg.sv
// Register map, STATUS bit positions and transmitter states
// shared by the MMIO UART transmitter and its bench.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory port as seen by the UART: strobe, byte enables,
// address and write data in; registered read data out.
interface mmio_uart_tx_if;

    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output en, wen, addr, data_i,
        input  data_o
    );

    modport slave (
        input  en, wen, addr, data_i,
        output data_o
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push ignored when
// full, pop ignored when empty, head visible combinationally.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(do_push);
        rptr_d = rptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register window on the
// data-memory port, byte FIFO, and a bit-timed serializer.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h0001_0000,
    parameter int          DEPTH   = 4,
    parameter logic [15:0] DIV_RST = 16'd15
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          txd,
    output logic          irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          hit, wr, rd;
    logic [1:0]    rsel;
    logic          push, pop;
    logic [7:0]    head;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [31:0]   status;

    logic [15:0]   div_q, div_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    tx_state_t     state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          unused_bits;

    assign hit  = bus.en && (bus.addr[31:4] == BASE[31:4]);
    assign rsel = bus.addr[3:2];
    assign wr   = hit && (bus.wen != 4'd0);
    assign rd   = hit && (bus.wen == 4'd0);
    assign push = wr && (rsel == REG_TXDATA) && bus.wen[0];

    assign unused_bits = ^{bus.addr[1:0], bus.data_i[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (bus.data_i[7:0]),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        status           = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = (state_q != IDLE);
        status[ST_OVF]   = ovf_q;
        status[ST_CNT +: 4] = 4'(count);
    end

    always_comb begin
        div_d   = div_q;
        ctrl_d  = ctrl_q;
        ovf_d   = ovf_q;
        rdata_d = '0;
        // full is the pre-edge state, so a same-cycle pop never rescues the byte
        if (push && full) begin
            ovf_d = 1'b1;
        end
        if (wr) begin
            unique case (rsel)
                REG_STATUS: if (bus.wen[0] && bus.data_i[ST_OVF]) ovf_d = 1'b0;
                REG_DIV: begin
                    if (bus.wen[0]) div_d[7:0]  = bus.data_i[7:0];
                    if (bus.wen[1]) div_d[15:8] = bus.data_i[15:8];
                end
                REG_CTRL:   if (bus.wen[0]) ctrl_d = bus.data_i[1:0];
                default: ;
            endcase
        end
        if (rd) begin
            unique case (rsel)
                REG_STATUS: rdata_d = status;
                REG_DIV:    rdata_d = {16'd0, div_q};
                REG_CTRL:   rdata_d = {30'd0, ctrl_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty && ctrl_q[0]) begin
                    pop     = 1'b1;
                    shift_d = head;
                    timer_d = div_q;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (timer_q == 16'd0) begin
                    state_d  = DATA;
                    timer_d  = div_q;
                    bitcnt_d = 3'd0;
                    txd_d    = shift_q[0];
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = div_q;
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        txd_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (timer_q == 16'd0) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= DIV_RST;
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
        end else begin
            div_q    <= div_d;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

    assign bus.data_o = rdata_q;
    assign txd        = txd_q;
    assign irq        = empty && ctrl_q[1];

endmodule
